// File: rtl/rpspmc_pkg.sv
// Shared constants and FSM encoding for the control-source ln path.
package rpspmc_pkg;

   localparam logic [31:0] LN2_Q032   = 32'hB172_17F8;
   localparam logic [31:0] LN_NEG_INF = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NORM  = 3'd1,
      ST_ITER  = 3'd2,
      ST_SCALE = 3'd3,
      ST_OUT   = 3'd4
   } ln_state_e;

endpackage

// File: rtl/msb_index32.sv
// Combinational priority encoder: index of the highest set bit, 0 for a zero input.
module msb_index32 (
   input  logic [31:0] din,
   output logic [4:0]  idx
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (din[i]) idx = 5'(i);
      end
   end

endmodule

// File: rtl/axis_ln_convert.sv
// Sequential ln(x): log2 by priority encode plus repeated squaring, then scale by ln2.
// Optional drop counter enabled by defining AXIS_LN_DROP_COUNT_EN.
module axis_ln_convert
   import rpspmc_pkg::*;
#(
   parameter int FRAC_BITS = 24
) (
   input  logic        a_clk,
   input  logic        a_rst,
   input  logic [31:0] S_AXIS_tdata,
   input  logic        S_AXIS_tvalid,
   output logic [31:0] M_AXIS_tdata,
   output logic        M_AXIS_tvalid,
   output logic        result_strobe,
   output logic        busy
`ifdef AXIS_LN_DROP_COUNT_EN
   ,
   output logic [15:0] drop_count
`endif
);

   localparam int LW = FRAC_BITS + 5;
   localparam int PW = LW + 32;

   ln_state_e              state_q, state_d;
   logic [31:0]            x_q, x_d;
   logic                   zero_q, zero_d;
   logic [4:0]             k_q, k_d;
   logic [31:0]            m_q, m_d;
   logic [FRAC_BITS-1:0]   frac_q, frac_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [31:0]            r_q, r_d;
   logic [31:0]            tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   strobe_q, strobe_d;

   logic [4:0]             msb_k;
   logic [63:0]            sq;
   logic [32:0]            sq_top;
   logic [LW-1:0]          l_val;
   logic [PW-1:0]          scaled;

   msb_index32 u_msb (
      .din (x_q),
      .idx (msb_k)
   );

   // One 32x32 multiplier serves every squaring step.
   assign sq     = 64'(m_q) * 64'(m_q);
   assign sq_top = 33'(sq >> 31);
   assign l_val  = {k_q, frac_q};
   assign scaled = PW'(l_val) * PW'(LN2_Q032);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      zero_d   = zero_q;
      k_d      = k_q;
      m_d      = m_q;
      frac_d   = frac_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      strobe_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (S_AXIS_tvalid) begin
               x_d     = S_AXIS_tdata;
               zero_d  = S_AXIS_tdata[31] | (S_AXIS_tdata == 32'd0);
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            k_d     = msb_k;
            m_d     = x_q << (5'd31 - msb_k);
            frac_d  = '0;
            cnt_d   = 5'(FRAC_BITS - 1);
            state_d = ST_ITER;
         end
         ST_ITER: begin
            // Square in Q2.62; a carry into bit 63 means m*m >= 2, so renormalise.
            m_d    = sq_top[32] ? sq_top[32:1] : sq_top[31:0];
            frac_d = {frac_q[FRAC_BITS-2:0], sq_top[32]};
            if (cnt_q == 5'd0) state_d = ST_SCALE;
            else               cnt_d   = cnt_q - 5'd1;
         end
         ST_SCALE: begin
            r_d     = zero_q ? LN_NEG_INF : 32'(scaled >> 32);
            state_d = ST_OUT;
         end
         ST_OUT: begin
            tdata_d  = r_q;
            tvalid_d = 1'b1;
            strobe_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         zero_q   <= 1'b0;
         k_q      <= '0;
         m_q      <= '0;
         frac_q   <= '0;
         cnt_q    <= '0;
         r_q      <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         zero_q   <= zero_d;
         k_q      <= k_d;
         m_q      <= m_d;
         frac_q   <= frac_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         strobe_q <= strobe_d;
      end
   end

   assign M_AXIS_tdata  = tdata_q;
   assign M_AXIS_tvalid = tvalid_q;
   assign result_strobe = strobe_q;
   assign busy          = (state_q != ST_IDLE);

`ifdef AXIS_LN_DROP_COUNT_EN
   logic [15:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (S_AXIS_tvalid && (state_q != ST_IDLE) && (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge a_clk) begin
      if (a_rst) drop_q <= '0;
      else       drop_q <= drop_d;
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_axis_ln_convert.sv
// Directed bench for axis_ln_convert with a real-arithmetic ln model and per-cycle compare.
module tb_axis_ln_convert;

   localparam int FRAC_BITS = 24;
   localparam int LAT       = FRAC_BITS + 4;

   logic        a_clk = 1'b0;
   logic        a_rst = 1'b1;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic [31:0] m_tdata;
   logic        m_tvalid, result_strobe, busy;
`ifdef AXIS_LN_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 a_clk = ~a_clk;

   axis_ln_convert #(.FRAC_BITS(FRAC_BITS)) dut (
      .a_clk         (a_clk),
      .a_rst         (a_rst),
      .S_AXIS_tdata  (s_tdata),
      .S_AXIS_tvalid (s_tvalid),
      .M_AXIS_tdata  (m_tdata),
      .M_AXIS_tvalid (m_tvalid),
      .result_strobe (result_strobe),
      .busy          (busy)
`ifdef AXIS_LN_DROP_COUNT_EN
      ,
      .drop_count    (drop_count)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   // ln(x) in Q8.24; truncation inside the converter only biases downward.
   function automatic bit res_ok(input logic [31:0] x, input logic [31:0] got);
      real e, d;
      if ($signed(x) <= 0) return got == 32'h8000_0000;
      e = $ln(real'(x)) * real'(1 << FRAC_BITS);
      d = e - real'($signed(got));
      return (d > -1.0) && (d < 3.0);
   endfunction

   // ---------------- model ----------------
   typedef struct { logic [31:0] x; int due; } job_t;
   job_t        jobs[$];
   int          cyc = 0;
   int          next_free = 0;
   int          drop_m = 0;
   logic        valid_m = 1'b0;
   logic [31:0] last_x = '0;
   bit          started = 1'b0;
   int          strobe_cyc[$];

   always @(posedge a_clk) begin
      if (a_rst) begin
         jobs.delete();
         next_free = 0;
         drop_m    = 0;
         valid_m   = 1'b0;
      end else if (s_tvalid) begin
         if (cyc >= next_free) begin
            jobs.push_back('{s_tdata, cyc + LAT});
            next_free = cyc + LAT;
         end else if (drop_m < 65535) begin
            drop_m++;
         end
      end
      cyc++;
      started = 1'b1;
   end

   logic exp_strobe, exp_busy;

   always @(negedge a_clk) begin
      if (started) begin
         exp_strobe = (jobs.size() > 0) && (jobs[0].due == cyc);
         exp_busy   = (jobs.size() > 0) && (cyc < jobs[0].due);
         if (exp_strobe) begin
            valid_m = 1'b1;
            last_x  = jobs[0].x;
            void'(jobs.pop_front());
         end
         if (result_strobe === 1'b1) strobe_cyc.push_back(cyc);
         chk1("strobe", result_strobe, exp_strobe);
         chk1("busy", busy, exp_busy);
         chk1("tvalid", m_tvalid, valid_m);
         if (valid_m) begin
            n_tests++;
            if (!res_ok(last_x, m_tdata)) begin
               n_fail++;
               $display("FAIL tdata: got 0x%08h for x=0x%08h (ln model out of range)", m_tdata, last_x);
            end
         end else begin
            chk("tdata_idle", m_tdata, 32'h0);
         end
`ifdef AXIS_LN_DROP_COUNT_EN
         chk("drop_count", 32'(drop_count), 32'(drop_m));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_one(input string nm, input logic [31:0] x, input bit use_lit,
                          input logic [31:0] lit);
      int n;
      @(negedge a_clk);
      s_tdata  = x;
      s_tvalid = 1'b1;
      @(negedge a_clk);
      s_tvalid = 1'b0;
      n = 1;
      while (result_strobe !== 1'b1 && n < LAT + 10) begin
         @(negedge a_clk);
         n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'(LAT));
      if (use_lit) chk({nm, "_value"}, m_tdata, lit);
   endtask

   initial begin
      repeat (3) @(negedge a_clk);
      chk("rst_tdata", m_tdata, 32'h0);
      chk1("rst_tvalid", m_tvalid, 1'b0);
      chk1("rst_strobe", result_strobe, 1'b0);
      chk1("rst_busy", busy, 1'b0);
`ifdef AXIS_LN_DROP_COUNT_EN
      chk("rst_drop", 32'(drop_count), 32'h0);
`endif
      a_rst = 1'b0;
      @(negedge a_clk);

      run_one("x1",    32'd1,          1'b1, 32'h0000_0000);
      run_one("x2",    32'd2,          1'b1, 32'h00B1_7217);
      run_one("x4",    32'd4,          1'b1, 32'h0162_E42F);
      run_one("x1024", 32'd1024,       1'b1, 32'h06EE_74EF);
      run_one("x2p30", 32'h4000_0000,  1'b1, 32'h14CB_5ECF);
      run_one("x0",    32'd0,          1'b1, 32'h8000_0000);
      run_one("xneg",  32'hFFFF_FFF0,  1'b1, 32'h8000_0000);
      repeat (3) @(negedge a_clk);
      chk1("tvalid_hold", m_tvalid, 1'b1);
      run_one("x3",    32'd3,          1'b0, 32'h0);
      run_one("x1000", 32'd1000,       1'b0, 32'h0);
      run_one("xmax",  32'h7FFF_FFFF,  1'b0, 32'h0);

      // Continuous input decimates to one conversion per LAT cycles.
      @(negedge a_clk);
      strobe_cyc.delete();
      s_tdata  = 32'd5;
      s_tvalid = 1'b1;
      repeat (100) @(negedge a_clk);
      s_tvalid = 1'b0;
      repeat (LAT + 5) @(negedge a_clk);
      chk("burst_strobes", 32'(strobe_cyc.size()), 32'd4);
      for (int i = 1; i < strobe_cyc.size(); i++)
         chk("burst_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'(LAT));
`ifdef AXIS_LN_DROP_COUNT_EN
      chk("burst_drops", 32'(drop_count), 32'd96);
`endif

      // Reset lands at cycle 10 of a conversion.
      @(negedge a_clk);
      s_tdata  = 32'd7;
      s_tvalid = 1'b1;
      @(negedge a_clk);
      s_tvalid = 1'b0;
      repeat (9) @(negedge a_clk);
      a_rst = 1'b1;
      @(negedge a_clk);
      a_rst = 1'b0;
      strobe_cyc.delete();
      chk("abort_tdata", m_tdata, 32'h0);
      chk1("abort_tvalid", m_tvalid, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_strobe", result_strobe, 1'b0);
      repeat (LAT + 5) @(negedge a_clk);
      chk("abort_no_strobe", 32'(strobe_cyc.size()), 32'd0);
      run_one("post_rst", 32'd1024, 1'b1, 32'h06EE_74EF);
      repeat (3) @(negedge a_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
